// File: rtl/lsu_pkg.sv
// Shared types, funct3 codes and access-legality predicates for the load/store unit.
package lsu_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StIssue,
      StRdata,
      StResp,
      StIssue2,
      StRdata2
   } lsu_state_t;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;
   localparam logic [2:0] F3_SB  = 3'b000;
   localparam logic [2:0] F3_SH  = 3'b001;
   localparam logic [2:0] F3_SW  = 3'b010;

   localparam logic [1:0] SizeHalf = 2'd1;
   localparam logic [1:0] SizeWord = 2'd2;

   // size is funct3[1:0]; off is the byte offset within the word
   function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
      return ((size == SizeHalf) && off[0]) || ((size == SizeWord) && (off != 2'b00));
   endfunction

   function automatic logic is_illegal(input logic store, input logic [2:0] f3);
      if (store) begin
         return f3 > F3_SW;
      end
      return (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
   endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational byte-lane placement for stores and lane select/extension for loads.
// Handles one or two words, so split accesses reuse the same logic.
module lsu_lane_align
   import lsu_pkg::*;
(
   input  logic [2:0]  funct3,
   input  logic [1:0]  offset,
   input  logic [31:0] wdata,
   input  logic [31:0] rdata_lo,
   input  logic [31:0] rdata_hi,
   output logic [3:0]  wstrb_lo,
   output logic [3:0]  wstrb_hi,
   output logic [31:0] wdata_lo,
   output logic [31:0] wdata_hi,
   output logic [31:0] rdata_ext
);

   logic [3:0]  mask;
   logic [31:0] wmasked;
   logic [7:0]  strb_wide;
   logic [63:0] wdata_wide;
   logic [31:0] shifted;

   always_comb begin
      mask    = 4'b1111;
      wmasked = wdata;
      unique case (funct3)
         F3_SB: begin
            mask    = 4'b0001;
            wmasked = {24'b0, wdata[7:0]};
         end
         F3_SH: begin
            mask    = 4'b0011;
            wmasked = {16'b0, wdata[15:0]};
         end
         default: ;
      endcase
      // lanes that spill past byte 3 belong to the following word
      strb_wide  = {4'b0000, mask} << offset;
      wdata_wide = {32'b0, wmasked} << {offset, 3'b000};
   end

   assign wstrb_lo = strb_wide[3:0];
   assign wstrb_hi = strb_wide[7:4];
   assign wdata_lo = wdata_wide[31:0];
   assign wdata_hi = wdata_wide[63:32];

   assign shifted = 32'({rdata_hi, rdata_lo} >> {offset, 3'b000});

   always_comb begin
      rdata_ext = shifted;
      unique case (funct3)
         F3_LB:   rdata_ext = {{24{shifted[7]}}, shifted[7:0]};
         F3_LBU:  rdata_ext = {24'b0, shifted[7:0]};
         F3_LH:   rdata_ext = {{16{shifted[15]}}, shifted[15:0]};
         F3_LHU:  rdata_ext = {16'b0, shifted[15:0]};
         F3_LW:   rdata_ext = shifted;
         default: rdata_ext = shifted;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory initiator: one load/store at a time, byte-strobed synchronous memory.
// Define LSU_SPLIT_MISALIGNED_EN to split misaligned accesses into two word accesses.
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int unsigned ADDR_W = 9
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_store,
   input  logic [2:0]        req_funct3,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic [31:0]       resp_rdata,
   output logic              resp_err,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [3:0]        mem_wstrb,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata
);

`ifdef LSU_SPLIT_MISALIGNED_EN
   localparam bit SplitEn = 1'b1;
`else
   localparam bit SplitEn = 1'b0;
`endif

   lsu_state_t        state;
   logic              store_q;
   logic [2:0]        f3_q;
   logic [ADDR_W-1:0] addr_q;
   logic [31:0]       wdata_q;
   logic [31:0]       rlo_q;
   logic              split_q;

   logic              req_mis;
   logic              req_err;
   logic [ADDR_W-1:0] word_addr;
   logic [31:0]       align_rlo;
   logic [3:0]        wstrb_lo;
   logic [3:0]        wstrb_hi;
   logic [31:0]       wdata_lo;
   logic [31:0]       wdata_hi;
   logic [31:0]       rdata_ext;

   assign req_mis   = is_misaligned(req_funct3[1:0], req_addr[1:0]);
   assign req_err   = is_illegal(req_store, req_funct3) | (req_mis & ~SplitEn);
   assign req_ready = (state == StIdle);
   assign word_addr = {addr_q[ADDR_W-1:2], 2'b00};
   // the second half of a split load combines the saved first word with the live one
   assign align_rlo = (state == StRdata2) ? rlo_q : mem_rdata;

   lsu_lane_align u_align (
      .funct3    (f3_q),
      .offset    (addr_q[1:0]),
      .wdata     (wdata_q),
      .rdata_lo  (align_rlo),
      .rdata_hi  (mem_rdata),
      .wstrb_lo  (wstrb_lo),
      .wstrb_hi  (wstrb_hi),
      .wdata_lo  (wdata_lo),
      .wdata_hi  (wdata_hi),
      .rdata_ext (rdata_ext)
   );

   always_comb begin
      mem_en    = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wstrb = 4'b0000;
      mem_wdata = 32'b0;
      if (!rst && (state == StIssue || state == StIssue2)) begin
         mem_en   = 1'b1;
         mem_we   = store_q;
         mem_addr = (state == StIssue2) ? word_addr + ADDR_W'(4) : word_addr;
         if (store_q) begin
            mem_wstrb = (state == StIssue2) ? wstrb_hi : wstrb_lo;
            mem_wdata = (state == StIssue2) ? wdata_hi : wdata_lo;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= StIdle;
         resp_valid <= 1'b0;
         resp_err   <= 1'b0;
         resp_rdata <= 32'b0;
      end else begin
         unique case (state)
            StIdle: begin
               if (req_valid) begin
                  store_q <= req_store;
                  f3_q    <= req_funct3;
                  addr_q  <= req_addr;
                  wdata_q <= req_wdata;
                  split_q <= req_mis;
                  if (req_err) begin
                     state      <= StResp;
                     resp_valid <= 1'b1;
                     resp_err   <= 1'b1;
                     resp_rdata <= 32'b0;
                  end else begin
                     state <= StIssue;
                  end
               end
            end
            StIssue: begin
               if (!store_q) begin
                  state <= StRdata;
               end else if (SplitEn && split_q) begin
                  state <= StIssue2;
               end else begin
                  state      <= StResp;
                  resp_valid <= 1'b1;
                  resp_err   <= 1'b0;
                  resp_rdata <= 32'b0;
               end
            end
            StRdata: begin
               if (SplitEn && split_q) begin
                  rlo_q <= mem_rdata;
                  state <= StIssue2;
               end else begin
                  state      <= StResp;
                  resp_valid <= 1'b1;
                  resp_err   <= 1'b0;
                  resp_rdata <= rdata_ext;
               end
            end
            StIssue2: begin
               if (store_q) begin
                  state      <= StResp;
                  resp_valid <= 1'b1;
                  resp_err   <= 1'b0;
                  resp_rdata <= 32'b0;
               end else begin
                  state <= StRdata2;
               end
            end
            StRdata2: begin
               state      <= StResp;
               resp_valid <= 1'b1;
               resp_err   <= 1'b0;
               resp_rdata <= rdata_ext;
            end
            StResp: begin
               if (resp_ready) begin
                  state      <= StIdle;
                  resp_valid <= 1'b0;
                  resp_err   <= 1'b0;
                  resp_rdata <= 32'b0;
               end
            end
            default: state <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: directed requests push expected responses,
// a negedge monitor pops and compares them on each response handshake.
module tb_load_store_unit;

   localparam int unsigned ADDR_W = 9;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              req_valid = 1'b0;
   logic              req_ready;
   logic              req_store = 1'b0;
   logic [2:0]        req_funct3 = 3'b000;
   logic [ADDR_W-1:0] req_addr = '0;
   logic [31:0]       req_wdata = 32'b0;
   logic              resp_valid;
   logic              resp_ready = 1'b1;
   logic [31:0]       resp_rdata;
   logic              resp_err;
   logic              mem_en;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [3:0]        mem_wstrb;
   logic [31:0]       mem_wdata;
   logic [31:0]       mem_rdata = 32'b0;

   always #5 clk = ~clk;

   load_store_unit #(.ADDR_W(ADDR_W)) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_store  (req_store),
      .req_funct3 (req_funct3),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_rdata (resp_rdata),
      .resp_err   (resp_err),
      .mem_en     (mem_en),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wstrb  (mem_wstrb),
      .mem_wdata  (mem_wdata),
      .mem_rdata  (mem_rdata)
   );

   logic [31:0] mem_arr [128];

   always @(posedge clk) begin
      if (mem_en) begin
         if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
               if (mem_wstrb[b]) mem_arr[mem_addr[8:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
            end
         end else begin
            mem_rdata <= mem_arr[mem_addr[8:2]];
         end
      end
   end

   int cyc = 0;
   int en_cnt = 0;
   always @(posedge clk) cyc <= cyc + 1;
   always @(posedge clk) if (mem_en) en_cnt <= en_cnt + 1;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          acc;
      int          lat;
   } exp_t;

   exp_t sb_q[$];
   exp_t mon_e;
   int   checks = 0;
   int   errors = 0;

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] lane_mask(input logic [3:0] s);
      logic [31:0] m;
      for (int b = 0; b < 4; b++) m[8*b +: 8] = {8{s[b]}};
      return m;
   endfunction

   always @(negedge clk) begin
      if (!rst && resp_valid && resp_ready) begin
         if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_resp: got rdata %h err %0d expected no response",
                     resp_rdata, resp_err);
         end else begin
            mon_e = sb_q.pop_front();
            check32("resp_rdata", resp_rdata, mon_e.rdata);
            check32("resp_err", 32'(resp_err), 32'(mon_e.err));
            if (mon_e.lat > 0) check32("latency", 32'(cyc - mon_e.acc), 32'(mon_e.lat));
         end
      end
   end

   // lat=0 skips the latency check; exp_strb=0 skips the write-lane check
   task automatic issue(input logic st, input logic [2:0] f3, input logic [8:0] a,
                        input logic [31:0] wd, input logic [31:0] exp_rd, input logic exp_err,
                        input int lat, input logic [3:0] exp_strb, input logic [31:0] exp_wd);
      int n = 0;
      @(negedge clk);
      while (!req_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!req_ready) begin
         checks++;
         errors++;
         $display("FAIL req_ready_timeout: got 0 expected 1");
         return;
      end
      req_store  = st;
      req_funct3 = f3;
      req_addr   = a;
      req_wdata  = wd;
      req_valid  = 1'b1;
      sb_q.push_back('{rdata: exp_rd, err: exp_err, acc: cyc, lat: lat});
      @(posedge clk);
      #1 req_valid = 1'b0;
      if (exp_strb != 4'b0000) begin
         @(negedge clk);
         check32("mem_we", 32'(mem_we), 32'd1);
         check32("mem_wstrb", 32'(mem_wstrb), 32'(exp_strb));
         check32("mem_wdata_lanes", mem_wdata & lane_mask(exp_strb), exp_wd);
      end
   endtask

   task automatic wait_idle();
      int n = 0;
      @(negedge clk);
      while (!(req_ready && sb_q.size() == 0) && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!(req_ready && sb_q.size() == 0)) begin
         checks++;
         errors++;
         $display("FAIL idle_timeout: got pending %0d expected 0", sb_q.size());
      end
   endtask

   int en0;
   int n;

   initial begin
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check32("reset_req_ready", 32'(req_ready), 32'd1);
      check32("reset_resp_valid", 32'(resp_valid), 32'd0);
      check32("reset_resp_err", 32'(resp_err), 32'd0);
      check32("reset_resp_rdata", resp_rdata, 32'd0);
      check32("reset_mem_en", 32'(mem_en), 32'd0);

      // store word then read back
      issue(1'b1, 3'b010, 9'h010, 32'hDEADBEEF, 32'h0, 1'b0, 2, 4'b1111, 32'hDEADBEEF);
      issue(1'b0, 3'b010, 9'h010, 32'h0, 32'hDEADBEEF, 1'b0, 3, 4'b0000, 32'h0);

      // sub-word loads with sign/zero extension
      issue(1'b1, 3'b010, 9'h064, 32'hABCDEF98, 32'h0, 1'b0, 2, 4'b1111, 32'hABCDEF98);
      issue(1'b0, 3'b000, 9'h064, 32'h0, 32'hFFFFFF98, 1'b0, 3, 4'b0000, 32'h0);
      issue(1'b0, 3'b100, 9'h064, 32'h0, 32'h00000098, 1'b0, 3, 4'b0000, 32'h0);
      issue(1'b0, 3'b001, 9'h066, 32'h0, 32'hFFFFABCD, 1'b0, 3, 4'b0000, 32'h0);
      issue(1'b0, 3'b101, 9'h066, 32'h0, 32'h0000ABCD, 1'b0, 3, 4'b0000, 32'h0);

      // byte store into lane 1
      issue(1'b1, 3'b010, 9'h020, 32'h11223344, 32'h0, 1'b0, 2, 4'b1111, 32'h11223344);
      issue(1'b1, 3'b000, 9'h021, 32'h00000055, 32'h0, 1'b0, 2, 4'b0010, 32'h00005500);
      issue(1'b0, 3'b010, 9'h020, 32'h0, 32'h11225544, 1'b0, 3, 4'b0000, 32'h0);

      // misaligned word load
      issue(1'b1, 3'b010, 9'h010, 32'h44332211, 32'h0, 1'b0, 2, 4'b1111, 32'h44332211);
      issue(1'b1, 3'b010, 9'h014, 32'h88776655, 32'h0, 1'b0, 2, 4'b1111, 32'h88776655);
      wait_idle();
      en0 = en_cnt;
`ifdef LSU_SPLIT_MISALIGNED_EN
      issue(1'b0, 3'b010, 9'h012, 32'h0, 32'h66554433, 1'b0, 5, 4'b0000, 32'h0);
      wait_idle();
      check32("misaligned_mem_en_pulses", 32'(en_cnt - en0), 32'd2);
`else
      issue(1'b0, 3'b010, 9'h012, 32'h0, 32'h0, 1'b1, 1, 4'b0000, 32'h0);
      wait_idle();
      check32("misaligned_mem_en_pulses", 32'(en_cnt - en0), 32'd0);
`endif

      // response backpressure
      resp_ready = 1'b0;
      issue(1'b0, 3'b010, 9'h064, 32'h0, 32'hABCDEF98, 1'b0, 0, 4'b0000, 32'h0);
      n = 0;
      while (!resp_valid && n < 20) begin
         @(negedge clk);
         n++;
      end
      check32("hold_resp_seen", 32'(resp_valid), 32'd1);
      repeat (4) begin
         @(negedge clk);
         check32("hold_resp_valid", 32'(resp_valid), 32'd1);
         check32("hold_resp_rdata", resp_rdata, 32'hABCDEF98);
         check32("hold_req_ready", 32'(req_ready), 32'd0);
      end
      @(posedge clk);
      #1 resp_ready = 1'b1;
      wait_idle();

      // illegal funct3: no memory access, 1-cycle error response
      en0 = en_cnt;
      issue(1'b0, 3'd7, 9'h020, 32'h0, 32'h0, 1'b1, 1, 4'b0000, 32'h0);
      issue(1'b1, 3'd3, 9'h020, 32'hFFFFFFFF, 32'h0, 1'b1, 1, 4'b0000, 32'h0);
      wait_idle();
      check32("illegal_mem_en_pulses", 32'(en_cnt - en0), 32'd0);

      // reset during a store's ISSUE cycle
      issue(1'b1, 3'b010, 9'h040, 32'h0BADF00D, 32'h0, 1'b0, 2, 4'b1111, 32'h0BADF00D);
      wait_idle();
      @(negedge clk);
      req_store  = 1'b1;
      req_funct3 = 3'b010;
      req_addr   = 9'h040;
      req_wdata  = 32'hFFFFFFFF;
      req_valid  = 1'b1;
      @(posedge clk);
      #1 req_valid = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      check32("rst_mem_we", 32'(mem_we), 32'd0);
      check32("rst_mem_en", 32'(mem_en), 32'd0);
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check32("post_rst_req_ready", 32'(req_ready), 32'd1);
      check32("post_rst_resp_valid", 32'(resp_valid), 32'd0);
      issue(1'b0, 3'b010, 9'h040, 32'h0, 32'h0BADF00D, 1'b0, 3, 4'b0000, 32'h0);
      wait_idle();

      check32("scoreboard_empty", 32'(sb_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Initiator side of the data-memory interface: accepts one load/store request at a time from the MEM stage.
- Drives a word-wide, byte-strobed, single-ported synchronous memory and returns the result on a response handshake.
- Lane handling lives here: byte/half placement, write strobes, sign/zero extension, misalignment and illegal-funct3 detection.
- Memory is little-endian: byte at address A lands on bits [8*(A%4)+7 : 8*(A%4)].

Parameters:
- ADDR_W, 9, byte-address width; addresses wrap modulo 2^ADDR_W.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  unit can accept a request; high only in IDLE
- req_store  in  1  1=store, 0=load
- req_funct3  in  3  RV32I load/store funct3: LB/LH/LW/LBU/LHU or SB/SH/SW
- req_addr  in  ADDR_W  byte address
- req_wdata  in  32  store data, right-justified
- resp_valid  out  1  response present
- resp_ready  in  1  response consumed
- resp_rdata  out  32  extended load data; 0 for stores and errors
- resp_err  out  1  misaligned access or illegal funct3
- mem_en  out  1  memory access this cycle
- mem_we  out  1  write enable
- mem_addr  out  ADDR_W  word address, low two bits always 0
- mem_wstrb  out  4  byte-lane write strobes
- mem_wdata  out  32  lane-shifted store data
- mem_rdata  in  32  read word, valid the cycle after mem_en with mem_we=0

Behaviour:
- States: IDLE, ISSUE, RDATA, RESP. With the optional feature, also ISSUE2 and RDATA2.
- Reset (rst high at a clock edge): state becomes IDLE; resp_valid=0, resp_err=0, resp_rdata=0.
- Memory outputs are decoded from state and forced to 0 while rst is high, so no write ever occurs in a reset cycle. This also holds for reset arriving mid-request, which discards the request with no response.
- Handshake: a request is accepted when req_valid and req_ready are both high at the T0 edge; request fields are registered at that edge.
- ISSUE (T1):
  - mem_en=1.
  - Store: mem_we=1, strobes and data are shifted by addr[1:0]. SB gives wstrb=0001<<a. SH gives 0011<<a. SW gives 1111.
  - Store goes to RESP; load goes to RDATA.
- RDATA (T2): capture mem_rdata, select lane, extend per funct3, go to RESP.
- RESP:
  - resp_valid=1; outputs are held stable until resp_ready.
  - On resp_ready, go to IDLE. req_ready returns high the next cycle (no same-cycle back-to-back).
- Latency from acceptance to resp_valid with resp_ready tied high:
  - aligned load: 3 cycles
  - aligned store: 2 cycles
- Illegal funct3:
  - load funct3 of 3, 6 or 7; store funct3 greater than 2.
  - No memory access; go directly to RESP with resp_err=1, resp_rdata=0 (1 cycle).
- Misaligned: halfword with addr[0]=1, or word with addr[1:0]!=0. Handled per the Optional Feature.

Optional Feature:
- Macro: LSU_SPLIT_MISALIGNED_EN.
- Without the macro: a misaligned access is treated like illegal funct3. resp_err=1, no memory access, 1-cycle response.
- With the macro: a misaligned access is split into two word accesses.
  - The first access is at the aligned word A&~3 (ISSUE/RDATA).
  - The second is at (A&~3)+4 modulo 2^ADDR_W (ISSUE2/RDATA2).
  - Store strobes and data are split across the two words. Loads concatenate the relevant bytes, then extend.
  - Latency: misaligned load 5 cycles, misaligned store 3 cycles.
  - resp_err=0. An illegal funct3 still errors.

Decomposition:
- lsu_pkg holds:
  - state encoding
  - funct3 constants, shared with the existing define set: F3_LB/LH/LW/LBU/LHU/SB/SH/SW
  - misalignment predicate
- One sub-module, lsu_lane_align (combinational):
  - store path: wdata/addr[1:0]/funct3 to wstrb/wdata
  - load path: rdata word(s)/addr[1:0]/funct3 to extended data
  - It is reused for both halves of a split access.

Test Plan:
- SW addr=0x10 data=0xDEADBEEF, then LW 0x10 -> store response at +2 cycles with mem_wstrb=1111. Load response at +3 with rdata=0xDEADBEEF, err=0.
- Memory word at 0x64 = 0xABCDEF98:
  - LB 0x64 -> 0xFFFFFF98
  - LBU 0x64 -> 0x00000098
  - LH 0x66 -> 0xFFFFABCD
  - LHU 0x66 -> 0x0000ABCD
- SB addr=0x21 data=0x55 onto word 0x11223344 -> mem_wstrb=0010, mem_wdata[15:8]=0x55; reading the word back gives 0x11225544.
- LW addr=0x12:
  - without the macro -> resp_err=1, rdata=0, mem_en never asserted.
  - with the macro and words 0x10=0x44332211, 0x14=0x88776655 -> rdata=0x66554433, two mem_en pulses.
- Hold resp_ready low for 4 cycles -> resp_valid and resp_rdata stable, req_ready low throughout. Assert a load funct3=7 afterwards -> err=1.
- Assert rst during a store's ISSUE cycle -> mem_we=0 in that cycle, memory unchanged, no response, req_ready=1 the cycle after reset deasserts.
